// File: rtl/seg_pkg.sv
`default_nettype none
// =============================================================================
// Package : seg_pkg
// Shared FSM state type and constants for the seven-segment scan driver.
// Rev     : 1.0
// =============================================================================
package seg_pkg;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    localparam logic [3:0] ANODES_OFF = 4'hF;
    localparam logic [6:0] SEG_OFF    = 7'h7F;

    // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage
`default_nettype wire

// File: rtl/seg_scan_driver_hex_to_7seg.sv
`default_nettype none
// =============================================================================
// Module : hex_to_7seg
// Combinational hex nibble to active-low seven-segment glyph decoder.
// Rev    : 1.0
// =============================================================================
module hex_to_7seg
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (hex_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            4'hF: seg_o = GLYPH_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// =============================================================================
// Module : seg_scan_driver
// Four-digit multiplexed seven-segment driver: inter-digit blanking, per-digit
// blink and optional leading-zero suppression, stepped by an external scan tick.
// Rev    : 1.0
// =============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_TICKS  = 333,
    parameter bit          LZ_SUPPRESS  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_666,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blink_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  scan_idx
);

    localparam int CNT_W   = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_TICKS  > 1) ? $clog2(BLINK_TICKS)  : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    logic               sync1_q, sync2_q, hist_q;
    logic               step;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [15:0]        shd_digits_q, shd_digits_d;
    logic [3:0]         shd_dp_q, shd_dp_d;
    logic [3:0]         shd_blink_q, shd_blink_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [3:0]         digit_sel;
    logic [6:0]         glyph;
    logic               blink_off, lz_off;

    // clk_666 is only sampled; the step is a one-clk pulse on its rising edge
    assign step = sync2_q & ~hist_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shd_digits_d = shd_digits_q;
        shd_dp_d     = shd_dp_q;
        shd_blink_d  = shd_blink_q;
        blink_cnt_d  = blink_cnt_q;
        phase_d      = phase_q;
        case (state_q)
            ST_SHOW: begin
                if (step) begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BLANK;
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                    // Inputs are frozen for a whole frame, taken as the scan wraps
                    if (idx_q == 2'd3) begin
                        shd_digits_d = digits_in;
                        shd_dp_d     = dp_in;
                        shd_blink_d  = blink_en;
                    end
                end
            end
            ST_BLANK: begin
                if (cnt_q == '0) begin
                    state_d = ST_SHOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // Output registers are loaded from next-state values so they track the FSM without lag
    assign digit_sel = shd_digits_d[{idx_d, 2'b00} +: 4];
    assign blink_off = phase_d & shd_blink_d[idx_d];
    assign lz_off    = LZ_SUPPRESS &&
                       (((idx_d == 2'd3) && (shd_digits_d[15:12] == 4'h0)) ||
                        ((idx_d == 2'd2) && (shd_digits_d[15:8]  == 8'h00)) ||
                        ((idx_d == 2'd1) && (shd_digits_d[15:4]  == 12'h000)));

    hex_to_7seg u_hex (
        .hex_i (digit_sel),
        .seg_o (glyph)
    );

    always_comb begin
        an_d  = ANODES_OFF;
        seg_d = glyph;
        dp_d  = ~shd_dp_d[idx_d];
        if ((state_d == ST_SHOW) && !blink_off && !lz_off) begin
            an_d = ANODES_OFF & ~(4'b0001 << idx_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            hist_q       <= 1'b0;
            state_q      <= ST_BLANK;
            cnt_q        <= CNT_LOAD;
            idx_q        <= 2'd0;
            shd_digits_q <= 16'h0000;
            shd_dp_q     <= 4'h0;
            shd_blink_q  <= 4'h0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            an_q         <= ANODES_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
        end else begin
            sync1_q      <= clk_666;
            sync2_q      <= sync1_q;
            hist_q       <= sync2_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shd_digits_q <= shd_digits_d;
            shd_dp_q     <= shd_dp_d;
            shd_blink_q  <= shd_blink_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign scan_idx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// =============================================================================
// Module : tb_seg_scan_driver
// Self-checking bench: two driver instances (leading-zero blanking off/on)
// compared every cycle against a behavioural model of the scan display.
// Rev    : 1.0
// =============================================================================
module tb_seg_scan_driver;

    localparam int BC = 16;
    localparam int BT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_666;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blink_en;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;
    logic [1:0]  idx0, idx1;

    int n_checks;
    int n_err;
    bit lz_watch;

    seg_scan_driver #(.BLANK_CYCLES(BC), .BLINK_TICKS(BT), .LZ_SUPPRESS(1'b0)) u_dut_plain (
        .clk(clk), .rst_n(rst_n), .clk_666(clk_666), .digits_in(digits_in),
        .dp_in(dp_in), .blink_en(blink_en),
        .an(an0), .seg(seg0), .dp(dp0), .scan_idx(idx0)
    );

    seg_scan_driver #(.BLANK_CYCLES(BC), .BLINK_TICKS(BT), .LZ_SUPPRESS(1'b1)) u_dut_lz (
        .clk(clk), .rst_n(rst_n), .clk_666(clk_666), .digits_in(digits_in),
        .dp_in(dp_in), .blink_en(blink_en),
        .an(an1), .seg(seg1), .dp(dp1), .scan_idx(idx1)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Time is counted in clk edges since reset release; a digit is lit once
    // the edge count reaches show_at, which each accepted step pushes BC ahead.
    int       m_now, m_show_at, m_steps, m_idx;
    int       m_dig [4];
    bit       m_dp  [4];
    bit       m_bl  [4];
    bit [2:0] m_hist;

    always @(posedge clk or negedge rst_n) begin : p_model
        bit stepped;
        bit was_lit_phase;
        if (!rst_n) begin
            m_now = 0; m_show_at = BC; m_steps = 0; m_idx = 0; m_hist = 3'b000;
            for (int k = 0; k < 4; k++) begin m_dig[k] = 0; m_dp[k] = 0; m_bl[k] = 0; end
        end else begin
            stepped       = m_hist[1] && !m_hist[2];
            was_lit_phase = (m_now >= m_show_at);
            m_now         = m_now + 1;
            if (was_lit_phase && stepped) begin
                m_idx     = (m_idx + 1) % 4;
                m_steps   = m_steps + 1;
                m_show_at = m_now + BC;
                if (m_idx == 0) begin
                    for (int k = 0; k < 4; k++) begin
                        m_dig[k] = int'(digits_in[4*k +: 4]);
                        m_dp[k]  = dp_in[k];
                        m_bl[k]  = blink_en[k];
                    end
                end
            end
            m_hist = {m_hist[1:0], clk_666};
        end
    end

    function automatic logic [6:0] glyph_of(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic void expected(input bit lz, output logic [3:0] a, output logic [6:0] s,
                                     output logic d, output logic [1:0] ix);
        bit dark;
        bit all_zero;
        if (m_now == 0) begin
            a = 4'hF; s = 7'h7F; d = 1'b1; ix = 2'd0;
        end else begin
            dark = (((m_steps / BT) % 2) == 1) && m_bl[m_idx];
            all_zero = 1'b1;
            for (int k = m_idx; k < 4; k++) if (m_dig[k] != 0) all_zero = 1'b0;
            if (lz && m_idx > 0 && all_zero) dark = 1'b1;
            a  = (m_now >= m_show_at && !dark) ? (4'hF & ~(4'b0001 << m_idx)) : 4'hF;
            s  = glyph_of(m_dig[m_idx]);
            d  = !m_dp[m_idx];
            ix = 2'(m_idx);
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [3:0] ea; logic [6:0] es; logic ed; logic [1:0] ei;
        expected(1'b0, ea, es, ed, ei);
        chk("plain.an", 32'(an0), 32'(ea));   chk("plain.seg", 32'(seg0), 32'(es));
        chk("plain.dp", 32'(dp0), 32'(ed));   chk("plain.idx", 32'(idx0), 32'(ei));
        expected(1'b1, ea, es, ed, ei);
        chk("lz.an", 32'(an1), 32'(ea));      chk("lz.seg", 32'(seg1), 32'(es));
        chk("lz.dp", 32'(dp1), 32'(ed));      chk("lz.idx", 32'(idx1), 32'(ei));
        if (lz_watch)
            chk("lz.no_leading_anode", 32'(an1 == 4'b0111 || an1 == 4'b1011 || an1 == 4'b1101), 32'd0);
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] idx_before;
        int half;
        n_checks = 0; n_err = 0; lz_watch = 1'b0;
        rst_n = 1'b0; clk_666 = 1'b0; digits_in = 16'h0000; dp_in = 4'h0; blink_en = 4'h0;

        repeat (3) tick();
        chk("reset.an", 32'(an1), 32'h0000000F);
        chk("reset.seg", 32'(seg1), 32'h0000007F);
        chk("reset.dp", 32'(dp1), 32'd1);

        rst_n = 1'b1;
        repeat (15) tick();
        chk("release.an_dark_15", 32'(an0), 32'h0000000F);
        tick();
        chk("release.an_16", 32'(an0), 32'(4'b1110));
        chk("release.seg_16", 32'(seg0), 32'h00000040);
        chk("release.dp_16", 32'(dp0), 32'd1);
        chk("release.idx_16", 32'(idx0), 32'd0);

        // Two frames of 0005 with leading-zero blanking
        digits_in = 16'h0005;
        for (int p = 0; p < 8; p++) begin
            clk_666 = 1'b1;
            repeat (19) tick();
            if (p == 3) begin
                chk("lz.digit0_an", 32'(an1), 32'(4'b1110));
                chk("lz.digit0_seg", 32'(seg1), 32'h00000012);
                lz_watch = 1'b1;
            end
            tick();
            clk_666 = 1'b0;
            repeat (20) tick();
        end
        lz_watch = 1'b0;

        // Sub-cycle glitch must not step the scan
        idx_before = idx0;
        clk_666 = 1'b1; #2; clk_666 = 1'b0;
        repeat (10) tick();
        chk("glitch.idx", 32'(idx0), 32'(idx_before));

        // Second rising edge inside the blank window is ignored
        clk_666 = 1'b1; repeat (4) tick();
        clk_666 = 1'b0; repeat (2) tick();
        clk_666 = 1'b1; repeat (30) tick();
        clk_666 = 1'b0; repeat (20) tick();
        chk("double_edge.idx", 32'(idx0), 32'(2'(idx_before + 2'd1)));

        // Randomised run with a mid-run reset
        half = $urandom_range(1, 45);
        for (int c = 0; c < 4000; c++) begin
            tick();
            half = half - 1;
            if (half == 0) begin
                clk_666 = ~clk_666;
                half = $urandom_range(1, 45);
            end
            if ($urandom_range(0, 39) == 0)  digits_in = 16'($urandom) >> (4 * $urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0)  dp_in = 4'($urandom);
            if ($urandom_range(0, 99) == 0)  blink_en = 4'($urandom);
            if (c == 2000) rst_n = 1'b0;
            if (c == 2004) rst_n = 1'b1;
            if ($urandom_range(0, 299) == 0 && !clk_666) begin
                clk_666 = 1'b1; #2; clk_666 = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
